// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / left-justified / TDM serial audio transmitter with an internal BCLK divider
// Ports: clk_i system clock; rst_ni async active-low reset; en_i enable; mode_i 0=Philips 1=LJ
//        s_data_i/s_valid_i/s_ready_o frame handshake (ch0 in MSBs); underrun_o 1-clk empty-load flag
//        aud_bclk_o bit clock; aud_lrclk_o LRCLK (stereo) or FS pulse (TDM); aud_sda_o serial data MSB first
module i2s_tdm_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int BCLK_DIV = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic [NUM_CH*DATA_W-1:0] s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic                     underrun_o,
  output logic                     aud_bclk_o,
  output logic                     aud_lrclk_o,
  output logic                     aud_sda_o
);
  localparam int FRAME_L = NUM_CH * SLOT_W;
  localparam int FW      = NUM_CH * DATA_W;
  localparam int P_W     = $clog2(FRAME_L);
  localparam int D_W     = $clog2(BCLK_DIV);
  localparam int I_W     = $clog2(FW);
  logic [D_W-1:0] div_cnt, div_n;
  logic [P_W-1:0] p, p_n;
  logic [I_W-1:0] idx;
  logic [FW-1:0]  hold, active, act_n;
  logic           run, mode_q, hold_full, fall, load, sda_n, lrclk_n, bclk_n;
  int             q, slot, b;
  assign s_ready_o = !hold_full;
  // run is low on the first enabled cycle, which is forced to be a fall event at p=0
  always_comb begin
    fall    = !run || div_cnt == D_W'(BCLK_DIV - 1);
    div_n   = fall ? '0 : div_cnt + 1'b1;
    p_n     = !run ? '0 : !fall ? p : (p == P_W'(FRAME_L - 1)) ? '0 : p + 1'b1;
    q       = mode_q ? int'(p_n) : (p_n == '0 ? FRAME_L - 1 : int'(p_n) - 1);
    slot    = q / SLOT_W;
    b       = q % SLOT_W;
    load    = fall && q == 0;
    act_n   = load ? (hold_full ? hold : '0) : active;
    idx     = b < DATA_W ? I_W'(FW - 1 - slot * DATA_W - b) : '0;
    sda_n   = b < DATA_W && act_n[idx];
    lrclk_n = NUM_CH == 2 ? p_n >= P_W'(SLOT_W) : p_n == '0;
    bclk_n  = div_n >= D_W'(BCLK_DIV / 2);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt     <= '0;
      p           <= '0;
      run         <= 1'b0;
      mode_q      <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      active      <= '0;
      underrun_o  <= 1'b0;
      aud_bclk_o  <= 1'b0;
      aud_lrclk_o <= 1'b0;
      aud_sda_o   <= 1'b0;
    end else begin
      if (s_valid_i && !hold_full) hold <= s_data_i;
      // a load always consumes the old contents; a transfer can only land in an empty buffer
      hold_full   <= (s_valid_i && !hold_full) || (hold_full && !(en_i && load));
      if (!en_i) mode_q <= mode_i;
      run         <= en_i;
      div_cnt     <= en_i ? div_n : '0;
      p           <= en_i ? p_n : '0;
      active      <= en_i ? act_n : '0;
      underrun_o  <= en_i && load && !hold_full;
      aud_bclk_o  <= en_i && bclk_n;
      aud_lrclk_o <= en_i && lrclk_n;
      aud_sda_o   <= en_i && sda_n;
    end
  end
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: randomized self-checking bench for i2s_tdm_tx (stereo and TDM instances)
module tb_i2s_tdm_tx;
  localparam int BD = 4, FL = 32, T_FL = 128;
  logic clk = 0, rst_n = 0, en = 0, mode = 0, s_valid = 0;
  logic [31:0] s_data = '0;
  logic s_ready, und, bclk, lrclk, sda;
  logic t_en = 0, t_mode = 0, t_valid = 0;
  logic [95:0] t_data = '0;
  logic t_ready, t_und, t_bclk, t_lrclk, t_sda;
  int checks = 0, failures = 0;
  logic [1:0] cap_q[$], t_cap[$];
  logic [127:0] exp_fr[$];
  logic [31:0] drv_q[$];
  int xfer_at[$];
  int und_cnt = 0, und_long = 0, per_err = 0, since = 0;
  bit have_prev = 0, pb = 0, pu = 0, tpb = 0, rdy_prev = 0;

  always #5 clk = ~clk;

  i2s_tdm_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .s_data_i(s_data),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .underrun_o(und),
    .aud_bclk_o(bclk), .aud_lrclk_o(lrclk), .aud_sda_o(sda));

  i2s_tdm_tx #(.DATA_W(24), .SLOT_W(32), .NUM_CH(4), .BCLK_DIV(4)) tdm (
    .clk_i(clk), .rst_ni(rst_n), .en_i(t_en), .mode_i(t_mode), .s_data_i(t_data),
    .s_valid_i(t_valid), .s_ready_o(t_ready), .underrun_o(t_und),
    .aud_bclk_o(t_bclk), .aud_lrclk_o(t_lrclk), .aud_sda_o(t_sda));

  // capture {lrclk,sda} at every BCLK rise, BCLK period, underrun pulses
  always @(negedge clk) begin
    since++;
    if (bclk && !pb) begin
      cap_q.push_back({lrclk, sda});
      if (have_prev && since != BD) per_err++;
      have_prev = 1;
      since = 0;
    end
    if (!en || !rst_n) have_prev = 0;
    if (und) und_cnt++;
    if (und && pu) und_long++;
    pb = bclk;
    pu = und;
    if (t_bclk && !tpb) t_cap.push_back({t_lrclk, t_sda});
    tpb = t_bclk;
  end

  // frame source: offers drv_q head, pops after an accepted transfer
  always @(negedge clk) begin
    if (s_valid && rdy_prev) begin
      xfer_at.push_back(cap_q.size());
      void'(drv_q.pop_front());
    end
    rdy_prev = s_ready;
    s_valid = drv_q.size() > 0;
    if (s_valid) s_data = drv_q[0];
  end

  // stream model: BCLK k of a run; frame l of exp_fr feeds bits j = k (LJ) or k-1 (Philips)
  function automatic bit exp_sda(int k, bit md, int nch, int sw, int dw);
    int j, l, qq, sl, bb;
    logic [127:0] s;
    if (!md && k == 0) return 1'b0;
    j = md ? k : k - 1;
    l = j / (nch * sw);
    qq = j % (nch * sw);
    sl = qq / sw;
    bb = qq % sw;
    if (l >= exp_fr.size() || bb >= dw) return 1'b0;
    s = exp_fr[l] >> ((nch - 1 - sl) * dw);
    return s[dw - 1 - bb];
  endfunction

  function automatic bit exp_lr(int k, int nch, int sw);
    int pp = k % (nch * sw);
    return nch == 2 ? pp >= sw : pp == 0;
  endfunction

  task automatic wait_cap(input int n, input bit t);
    int i = 0;
    while ((t ? t_cap.size() : cap_q.size()) < n && i < 20000) begin
      @(negedge clk);
      i++;
    end
    if ((t ? t_cap.size() : cap_q.size()) < n) begin
      checks++;
      failures++;
      $display("FAIL wait_cap got=%0d need=%0d", t ? t_cap.size() : cap_q.size(), n);
    end
  endtask

  task automatic start_run(input bit md);
    mode = md;
    en = 0;
    repeat (4) @(negedge clk);
    en = 1;
    cap_q.delete();
    und_cnt = 0;
    und_long = 0;
    per_err = 0;
  endtask

  task automatic push_frame(input logic [31:0] f);
    drv_q.push_back(f);
    exp_fr.push_back({96'd0, f});
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
    checks++; if (bclk !== 1'b0) begin failures++; $display("FAIL rst_bclk got=%b exp=0", bclk); end
    checks++; if (lrclk !== 1'b0) begin failures++; $display("FAIL rst_lrclk got=%b exp=0", lrclk); end
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_sda got=%b exp=0", sda); end
    checks++; if (und !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", und); end
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++; if ({bclk, lrclk, sda} !== 3'b000) begin failures++; $display("FAIL idle_outputs got=%b exp=000", {bclk, lrclk, sda}); end
  endtask

  task automatic test_philips;
    exp_fr.delete();
    push_frame(32'hA5A5_0F0F);
    push_frame($urandom);
    push_frame($urandom);
    start_run(0);
    wait_cap(3 * FL + 1, 0);
    checks++; if (und_cnt !== 0) begin failures++; $display("FAIL philips_underrun got=%0d exp=0", und_cnt); end
    checks++; if (per_err !== 0) begin failures++; $display("FAIL bclk_period errors=%0d exp=0", per_err); end
    for (int k = 0; k <= 3 * FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), exp_sda(k, 0, 2, 16, 16)}) begin
        failures++;
        $display("FAIL philips_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), exp_sda(k, 0, 2, 16, 16)});
      end
    end
    en = 0;
    repeat (2) @(negedge clk);
    checks++; if ({bclk, lrclk, sda} !== 3'b000) begin failures++; $display("FAIL disable_outputs got=%b exp=000", {bclk, lrclk, sda}); end
  endtask

  task automatic test_left_justified;
    exp_fr.delete();
    push_frame(32'hA5A5_0F0F);
    push_frame($urandom);
    start_run(1);
    wait_cap(2 * FL, 0);
    checks++; if (und_cnt !== 0) begin failures++; $display("FAIL lj_underrun got=%0d exp=0", und_cnt); end
    for (int k = 0; k < 2 * FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)}) begin
        failures++;
        $display("FAIL lj_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)});
      end
    end
    en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun;
    exp_fr.delete();
    push_frame($urandom);
    start_run(1);
    wait_cap(FL + 4, 0);
    checks++; if (und_cnt !== 1) begin failures++; $display("FAIL underrun_pulse got=%0d exp=1", und_cnt); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL underrun_ready got=%b exp=1", s_ready); end
    exp_fr.push_back('0);
    push_frame(32'h1234_5678);
    wait_cap(3 * FL, 0);
    checks++; if (und_cnt !== 1) begin failures++; $display("FAIL underrun_total got=%0d exp=1", und_cnt); end
    checks++; if (und_long !== 0) begin failures++; $display("FAIL underrun_width got=%0d exp=0", und_long); end
    for (int k = 0; k < 3 * FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)}) begin
        failures++;
        $display("FAIL underrun_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)});
      end
    end
    en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_fr.delete();
    xfer_at.delete();
    for (int i = 0; i < 4; i++) push_frame($urandom);
    start_run(0);
    wait_cap(FL / 2, 0);
    mode = 1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready got=%b exp=0", s_ready); end
    wait_cap(4 * FL + 1, 0);
    checks++; if (und_cnt !== 0) begin failures++; $display("FAIL b2b_underrun got=%0d exp=0", und_cnt); end
    checks++; if (xfer_at.size() !== 4) begin failures++; $display("FAIL b2b_transfers got=%0d exp=4", xfer_at.size()); end
    for (int i = 1; i < 4 && i < xfer_at.size(); i++) begin
      checks++;
      if (xfer_at[i] / FL !== i - 1) begin
        failures++;
        $display("FAIL b2b_xfer_frame i=%0d got=%0d exp=%0d", i, xfer_at[i] / FL, i - 1);
      end
    end
    for (int k = 0; k <= 4 * FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), exp_sda(k, 0, 2, 16, 16)}) begin
        failures++;
        $display("FAIL b2b_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), exp_sda(k, 0, 2, 16, 16)});
      end
    end
    en = 0;
    mode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tdm;
    logic [95:0] f1, f2;
    int i;
    f1 = {$urandom, $urandom, $urandom};
    f2 = {$urandom, $urandom, $urandom};
    exp_fr.delete();
    exp_fr.push_back({32'd0, f1});
    exp_fr.push_back({32'd0, f2});
    t_mode = 0;
    @(negedge clk);
    t_valid = 1;
    t_data = f1;
    @(negedge clk);
    t_valid = 0;
    repeat (2) @(negedge clk);
    t_en = 1;
    t_cap.delete();
    i = 0;
    while (!t_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++; if (t_ready !== 1'b1) begin failures++; $display("FAIL tdm_ready got=%b exp=1", t_ready); end
    t_valid = 1;
    t_data = f2;
    @(negedge clk);
    t_valid = 0;
    wait_cap(2 * T_FL + 1, 1);
    for (int k = 0; k <= 2 * T_FL; k++) begin
      checks++;
      if (t_cap[k] !== {exp_lr(k, 4, 32), exp_sda(k, 0, 4, 32, 24)}) begin
        failures++;
        $display("FAIL tdm_bit k=%0d got=%b exp=%b", k, t_cap[k], {exp_lr(k, 4, 32), exp_sda(k, 0, 4, 32, 24)});
      end
    end
    t_en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    exp_fr.delete();
    push_frame($urandom);
    push_frame($urandom);
    start_run(0);
    wait_cap(21, 0);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL pre_reset_ready got=%b exp=0", s_ready); end
    #2;
    rst_n = 0;
    #1;
    checks++; if ({bclk, lrclk, sda, und} !== 4'b0000) begin failures++; $display("FAIL async_reset_outputs got=%b exp=0000", {bclk, lrclk, sda, und}); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b exp=1", s_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    cap_q.delete();
    exp_fr.delete();
    und_cnt = 0;
    wait_cap(FL + 1, 0);
    checks++; if (und_cnt !== 1) begin failures++; $display("FAIL post_reset_underrun got=%0d exp=1", und_cnt); end
    for (int k = 0; k <= FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), 1'b0}) begin
        failures++;
        $display("FAIL post_reset_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), 1'b0});
      end
    end
    wait_cap(FL + 21, 0);
    en = 0;
    mode = 1;
    repeat (2) @(negedge clk);
    checks++; if ({bclk, lrclk, sda} !== 3'b000) begin failures++; $display("FAIL midframe_disable got=%b exp=000", {bclk, lrclk, sda}); end
    exp_fr.delete();
    push_frame($urandom);
    start_run(1);
    wait_cap(FL, 0);
    checks++; if (und_cnt !== 0) begin failures++; $display("FAIL reenable_underrun got=%0d exp=0", und_cnt); end
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (cap_q[k] !== {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)}) begin
        failures++;
        $display("FAIL reenable_bit k=%0d got=%b exp=%b", k, cap_q[k], {exp_lr(k, 2, 16), exp_sda(k, 1, 2, 16, 16)});
      end
    end
    en = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_philips;
    test_left_justified;
    test_underrun;
    test_back_to_back;
    test_tdm;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
